// File: rtl/rom_image_loader.sv
// rom_image_loader: streams a 2**ADDR_W byte image into the RAM shadowing a
// program ROM, verifies an 8-bit additive checksum and keeps the game CPU in
// reset until a verified image is present.
module rom_image_loader #(
  parameter int ADDR_W = 13,
  parameter int BASE   = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ADDR_W-1:0] wr_a,
  output logic [7:0]        wr_d,
  output logic              wr_we,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic              cpu_hold
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CHECK,
    S_DONE,
    S_ERROR
  } state_t;

  // BASE is reduced modulo the ROM size by the truncating cast.
  localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(BASE);
  localparam logic [ADDR_W-1:0] LAST   = '1;

  // Running checksum accumulates modulo 256.
  function automatic logic [7:0] sum8(input logic [7:0] a, input logic [7:0] b);
    return a + b;
  endfunction

  // Write address for the n-th image byte, wrapping around the ROM space.
  function automatic logic [ADDR_W-1:0] addr_at(input logic [ADDR_W-1:0] n);
    return BASE_A + n;
  endfunction

  state_t            state, state_n;
  logic [ADDR_W-1:0] cnt, cnt_n;
  logic [7:0]        sum, sum_n;
  logic [ADDR_W-1:0] wr_a_n;
  logic [7:0]        wr_d_n;
  logic              wr_we_n;
  logic              done_n;
  logic              error_n;
  logic              xfer;
  logic              active_n;

  assign xfer     = in_valid && in_ready;
  assign active_n = (state_n == S_LOAD) || (state_n == S_CHECK);

  // Next-state and next-output logic; abort takes priority over a transfer.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    sum_n   = sum;
    wr_a_n  = wr_a;
    wr_d_n  = wr_d;
    wr_we_n = 1'b0;
    done_n  = done;
    error_n = error;
    case (state)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          state_n = S_LOAD;
          cnt_n   = '0;
          sum_n   = 8'd0;
          wr_a_n  = BASE_A;
          done_n  = 1'b0;
          error_n = 1'b0;
        end
      end
      S_LOAD: begin
        if (abort) begin
          state_n = S_ERROR;
          error_n = 1'b1;
        end else if (xfer) begin
          wr_we_n = 1'b1;
          wr_d_n  = in_data;
          wr_a_n  = addr_at(cnt);
          sum_n   = sum8(sum, in_data);
          cnt_n   = cnt + 1'b1;
          if (cnt == LAST) state_n = S_CHECK;
        end
      end
      S_CHECK: begin
        if (abort) begin
          state_n = S_ERROR;
          error_n = 1'b1;
        end else if (xfer) begin
          if (sum8(sum, in_data) == 8'd0) begin
            state_n = S_DONE;
            done_n  = 1'b1;
          end else begin
            state_n = S_ERROR;
            error_n = 1'b1;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // State, counters and all outputs are registered; reset is asynchronous.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      cnt      <= '0;
      sum      <= 8'd0;
      wr_a     <= BASE_A;
      wr_d     <= 8'd0;
      wr_we    <= 1'b0;
      in_ready <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
      cpu_hold <= 1'b1;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      sum      <= sum_n;
      wr_a     <= wr_a_n;
      wr_d     <= wr_d_n;
      wr_we    <= wr_we_n;
      in_ready <= active_n;
      busy     <= active_n;
      done     <= done_n;
      error    <= error_n;
      cpu_hold <= (state_n != S_DONE);
    end
  end

endmodule

// File: doc/rom_image_loader.md
Name: rom_image_loader

Overview:
- Writer-side counterpart of the 8Kx8 program ROMs (13-bit address, 8-bit data, synchronous read).
- Accepts a byte stream from the host/download path and writes it sequentially into the RAM that backs a ROM region.
- Verifies an 8-bit additive checksum and holds the game CPU off until a valid image is present.
- Sits between the download interface and the ROM-shadow RAM write port.

Parameters:
- ADDR_W, 13, width of the ROM address; the image length is 2**ADDR_W bytes.
- BASE, 0, first write address, mod 2**ADDR_W.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a load; honoured only in IDLE, DONE or ERROR.
- abort  in  1  one-cycle pulse that cancels a load in progress.
- in_data  in  8  stream byte.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  loader can accept a byte.
- wr_a  out  ADDR_W  RAM write address.
- wr_d  out  8  RAM write data.
- wr_we  out  1  RAM write strobe, one cycle per byte.
- busy  out  1  high in LOAD or CHECK.
- done  out  1  image loaded and checksum matched.
- error  out  1  checksum mismatch or abort.
- cpu_hold  out  1  holds the CPU in reset; high unless done.

Behaviour:
- Reset values (asynchronous):
  - state = IDLE.
  - in_ready, wr_we, busy, done, error = 0.
  - wr_a = BASE, wr_d = 0.
  - cpu_hold = 1.
  - Internal byte counter = 0, sum = 0.
- States are IDLE, LOAD, CHECK, DONE, ERROR.
- Transfer rule: a byte transfers on any rising edge where in_valid && in_ready. in_ready is a registered output, high only in LOAD and CHECK.
- IDLE/DONE/ERROR + start:
  - Next state LOAD.
  - Counter = 0, sum = 0, wr_a = BASE.
  - done = 0, error = 0, cpu_hold = 1.
  - in_ready goes high on the cycle after start.
- LOAD, per transferred byte:
  - On the following cycle: wr_we = 1, wr_d = byte, wr_a = BASE + counter (mod 2**ADDR_W).
  - Write latency is exactly 1 cycle after the transfer edge.
  - sum = sum + byte (mod 256); counter increments.
  - Back-to-back transfers produce back-to-back single-cycle wr_we.
- LOAD to CHECK: after the byte with counter = 2**ADDR_W - 1 transfers, the next state is CHECK.
- Address wrap: wr_a wraps modulo 2**ADDR_W when BASE != 0, so every address is written exactly once.
- CHECK:
  - Accept exactly one byte, with no RAM write for it.
  - If (sum + byte) mod 256 == 0: go to DONE. Set done = 1 and cpu_hold = 0 from the next cycle.
  - Otherwise: go to ERROR. Set error = 1; cpu_hold stays 1.
  - in_ready drops on the cycle after the checksum byte transfers.
- ERROR: holds until the next start; in_ready = 0.
- abort:
  - In LOAD or CHECK: go to ERROR next cycle, error = 1, in_ready = 0.
  - A write already scheduled for that cycle still completes. No further writes.
  - In other states abort is ignored.
- start and abort in the same cycle: abort wins if busy; otherwise start wins.
- start while busy: ignored.
- in_valid with in_ready low: no transfer and no state change.
- in_valid gaps: the loader waits indefinitely; there is no timeout.
- Reset mid-load: immediate return to the reset state. RAM contents are undefined; cpu_hold = 1.
- busy = (state == LOAD || state == CHECK), registered.

Test Plan:
- Full load, ADDR_W=13, BASE=0:
  - Stimulus: start, then bytes a[7:0] for a = 0..8191, then checksum = (-sum) mod 256.
  - Required: 8192 wr_we pulses with wr_a = a and wr_d = a[7:0], each one cycle after its transfer; checksum byte not written; done = 1, cpu_hold = 0, error = 0.
- Bad checksum: same stream with checksum + 1 -> error = 1, done = 0, cpu_hold = 1, in_ready = 0.
- Throttled source: random in_valid gaps of 0-5 cycles -> identical write sequence with no duplicated or lost bytes; wr_we count = 8192.
- Abort:
  - Stimulus: abort pulse after 100 transfers.
  - Required: at most 100 writes (addresses 0..99), error = 1 next cycle, in_ready = 0; a subsequent start plus a good image gives done = 1.
- Wrap and reset, BASE=8190:
  - Required: first writes go to 8190, 8191, 0, 1...
  - Asserting reset mid-load returns all outputs to reset values asynchronously (check before the next clk edge).
- Corner controls:
  - start while busy -> no effect.
  - Simultaneous start+abort while busy -> ERROR.
  - Simultaneous start+abort in DONE -> LOAD.
